frame_fetch_unit: RTL and testbench

//  Upstream pixel source for hdmi_transmitter. Serves its read_request/address_line pixel

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/sram_rd_pipe.sv | 57 +++++
 rtl/frame_fetch_unit.sv | 132 +++++++++++++
 tb/tb_frame_fetch_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the frame fetch unit.
//   fetch_state_t : FSM state encoding (IDLE, ISSUE, WAIT, RESP, HOLD)
//   pixel_t       : 24-bit {R,G,B} pixel
//   H_ACTIVE/BAR_W: geometry of the colour-bar test pattern
//   bar_pixel()   : colour-bar pixel for a linear pixel index
package fetch_pkg;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, HOLD} fetch_state_t;

    localparam int H_ACTIVE = 640;
    localparam int BAR_W    = 80;

    typedef logic [23:0] pixel_t;

    // Eight vertical bars; each bar index bit drives one full colour channel.
    function automatic pixel_t bar_pixel(input logic [19:0] addr);
        logic [2:0] bar;
        bar = 3'((32'(addr) % H_ACTIVE) / BAR_W);
        return {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// sram_rd_pipe: tracks SRAM reads in flight with a SRAM_LAT-deep valid/tag
// shift register, so data is captured only when a read we issued returns.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (drops reads in flight)
//   rd_en, rd_hi : read strobe sent to SRAM and which word it is (1 = high word)
//   rdata        : SRAM read data
//   lo_word      : last captured low word {G,B}
//   hi_byte      : R byte of the high word currently on rdata
//   hi_vld       : high word is on rdata this cycle
module sram_rd_pipe #(
    parameter int SRAM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        rd_hi,
    input  logic [15:0] rdata,
    output logic [15:0] lo_word,
    output logic [7:0]  hi_byte,
    output logic        hi_vld
);

    logic [SRAM_LAT-1:0] vld_pipe_q, vld_pipe_d;
    logic [SRAM_LAT-1:0] tag_pipe_q, tag_pipe_d;
    logic [15:0]         lo_q, lo_d;
    logic                tail_vld, tail_hi;

    assign tail_vld = vld_pipe_q[SRAM_LAT-1];
    assign tail_hi  = tag_pipe_q[SRAM_LAT-1];

    always_comb begin
        vld_pipe_d[0] = rd_en;
        tag_pipe_d[0] = rd_hi;
        for (int i = 1; i < SRAM_LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            tag_pipe_d[i] = tag_pipe_q[i-1];
        end
        lo_d = (tail_vld && !tail_hi) ? rdata : lo_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            tag_pipe_q <= '0;
            lo_q       <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            tag_pipe_q <= tag_pipe_d;
            lo_q       <= lo_d;
        end
    end

    assign lo_word = lo_q;
    assign hi_byte = rdata[7:0];
    assign hi_vld  = tail_vld & tail_hi;

endmodule

// File: rtl/frame_fetch_unit.sv
// frame_fetch_unit: serves pixel requests from hdmi_transmitter out of a
// 16-bit SRAM frame buffer (two words per pixel: low {G,B}, high [7:0] R).
// Ports:
//   system_clk, rst          : clock, synchronous active-high reset
//   read_request/address_line: level request and pixel index (sampled in IDLE)
//   data_line/data_ready     : pixel and DR_CYCLES-long response strobe
//   frame_done               : pulse on first response cycle of the last pixel
//   sram_addr/sram_rd_en     : SRAM word address and read strobe
//   sram_rdata               : SRAM data, SRAM_LAT cycles after the strobe
//   test_mode                : only with TEST_PATTERN_EN; colour bars, no SRAM
// Build option: define TEST_PATTERN_EN to add the test_mode port and pattern.
module frame_fetch_unit
    import fetch_pkg::*;
#(
    parameter int FRAME_PIXELS = 307200,
    parameter int SRAM_LAT     = 2,
    parameter int DR_CYCLES    = 2
) (
    input  logic        system_clk,
    input  logic        rst,
    input  logic        read_request,
    input  logic [19:0] address_line,
    output pixel_t      data_line,
    output logic        data_ready,
    output logic        frame_done,
    output logic [20:0] sram_addr,
    output logic        sram_rd_en,
    input  logic [15:0] sram_rdata
`ifdef TEST_PATTERN_EN
    ,
    input  logic        test_mode
`endif
);

    fetch_state_t state_q, state_d;
    logic [19:0]  addr_q, addr_d;
    logic         hi_q, hi_d;          // ISSUE: 0 = low word strobe, 1 = high word
    logic [2:0]   dr_cnt_q, dr_cnt_d;  // cycles spent in RESP
    pixel_t       data_line_q, data_line_d;

    logic [15:0]  lo_word;
    logic [7:0]   hi_byte;
    logic         hi_vld;
    logic         in_range;

    assign in_range = 32'(address_line) < 32'(FRAME_PIXELS);

    sram_rd_pipe #(.SRAM_LAT(SRAM_LAT)) u_rd_pipe (
        .clk     (system_clk),
        .rst     (rst),
        .rd_en   (sram_rd_en),
        .rd_hi   (hi_q),
        .rdata   (sram_rdata),
        .lo_word (lo_word),
        .hi_byte (hi_byte),
        .hi_vld  (hi_vld)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        hi_d        = hi_q;
        dr_cnt_d    = dr_cnt_q;
        data_line_d = data_line_q;
        case (state_q)
            IDLE: begin
                if (read_request) begin
                    addr_d   = address_line;
                    hi_d     = 1'b0;
                    dr_cnt_d = '0;
                    if (!in_range) begin
                        data_line_d = '0;
                        state_d     = RESP;
                    end
`ifdef TEST_PATTERN_EN
                    else if (test_mode) begin
                        data_line_d = bar_pixel(address_line);
                        state_d     = RESP;
                    end
`endif
                    else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                hi_d = 1'b1;
                if (hi_q) state_d = WAIT;
            end
            WAIT: begin
                // Low word is already held in the pipe; high word is live on rdata.
                if (hi_vld) begin
                    data_line_d = {hi_byte, lo_word};
                    state_d     = RESP;
                end
            end
            RESP: begin
                dr_cnt_d = dr_cnt_q + 3'd1;
                if (dr_cnt_q == 3'(DR_CYCLES - 1)) state_d = HOLD;
            end
            HOLD: begin
                // A level request held across the response must not refetch.
                if (!read_request) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge system_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            hi_q        <= 1'b0;
            dr_cnt_q    <= '0;
            data_line_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            hi_q        <= hi_d;
            dr_cnt_q    <= dr_cnt_d;
            data_line_q <= data_line_d;
        end
    end

    assign sram_rd_en = (state_q == ISSUE);
    assign sram_addr  = (state_q == ISSUE) ? {addr_q, hi_q} : '0;
    assign data_line  = data_line_q;
    assign data_ready = (state_q == RESP);
    assign frame_done = (state_q == RESP) && (dr_cnt_q == '0) &&
                        (addr_q == 20'(FRAME_PIXELS - 1));

endmodule

// File: tb/tb_frame_fetch_unit.sv
// Bench for frame_fetch_unit: SRAM model with fixed 2-cycle latency and
// data = f(address). "Cycle k" of a request is the cycle after edge N+k-1,
// sampled on the falling edge.
module tb_frame_fetch_unit;

    logic        system_clk = 1'b0;
    logic        rst, read_request;
    logic [19:0] address_line;
    logic [23:0] data_line;
    logic        data_ready, frame_done, sram_rd_en;
    logic [20:0] sram_addr;
    logic [15:0] sram_rdata;
`ifdef TEST_PATTERN_EN
    logic        test_mode;
`endif

    int total = 0;
    int bad   = 0;

    always #5 system_clk = ~system_clk;

    frame_fetch_unit dut (
        .system_clk   (system_clk),
        .rst          (rst),
        .read_request (read_request),
        .address_line (address_line),
        .data_line    (data_line),
        .data_ready   (data_ready),
        .frame_done   (frame_done),
        .sram_addr    (sram_addr),
        .sram_rd_en   (sram_rd_en),
        .sram_rdata   (sram_rdata)
`ifdef TEST_PATTERN_EN
        ,
        .test_mode    (test_mode)
`endif
    );

    function automatic logic [15:0] sram_f(input logic [20:0] a);
        logic [31:0] x;
        if (a == 21'd10) return 16'hBBCC;
        if (a == 21'd11) return 16'h00AA;
        x = 32'(a) * 32'd40503;
        return x[15:0] ^ 16'h1234;
    endfunction

    function automatic logic [23:0] pix(input logic [19:0] p);
        logic [15:0] lo, hi;
        lo = sram_f({p, 1'b0});
        hi = sram_f({p, 1'b1});
        return {hi[7:0], lo};
    endfunction

    // SRAM model: 2-stage read pipeline, not reset, junk when idle.
    logic [15:0] st0, st1;
    always @(posedge system_clk) begin
        st0 <= sram_rd_en ? sram_f(sram_addr) : 16'hDEAD;
        st1 <= st0;
    end
    assign sram_rdata = st1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // One request, request dropped after edge N; records 8 cycles.
    task automatic run_req(input logic [19:0] a,
                           output logic [7:0] en_m, output logic [7:0] dr_m,
                           output logic [7:0] fd_m, output logic [23:0] dl,
                           output logic [20:0] a1, output logic [20:0] a2);
        logic seen;
        en_m = '0; dr_m = '0; fd_m = '0; dl = 24'hEEEEEE; a1 = '0; a2 = '0; seen = 1'b0;
        @(negedge system_clk);
        read_request = 1'b1;
        address_line = a;
        @(posedge system_clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge system_clk);
            if (k == 1) read_request = 1'b0;
            en_m[k-1] = sram_rd_en;
            dr_m[k-1] = data_ready;
            fd_m[k-1] = frame_done;
            if (k == 1) a1 = sram_addr;
            if (k == 2) a2 = sram_addr;
            if (data_ready && !seen) begin
                dl   = data_line;
                seen = 1'b1;
            end
        end
    endtask

    typedef struct {
        logic [19:0] addr;
        logic [23:0] pix;
        logic [7:0]  en_m;
        logic [7:0]  dr_m;
        logic [7:0]  fd_m;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [7:0]  en_m, dr_m, fd_m;
        logic [23:0] dl;
        logic [20:0] a1, a2;
        int          strobes, bursts;
        logic        prev;

        vecs[0] = '{20'd5,      24'hAABBCC,   8'h03, 8'h30, 8'h00};
        vecs[1] = '{20'd307199, pix(307199),  8'h03, 8'h30, 8'h10};
        vecs[2] = '{20'd307198, pix(307198),  8'h03, 8'h30, 8'h00};
        vecs[3] = '{20'd400000, 24'h000000,   8'h00, 8'h03, 8'h00};
        vecs[4] = '{20'd307200, 24'h000000,   8'h00, 8'h03, 8'h00};
        vecs[5] = '{20'd0,      pix(0),       8'h03, 8'h30, 8'h00};
        vecs[6] = '{20'd1234,   pix(1234),    8'h03, 8'h30, 8'h00};

        rst = 1'b1; read_request = 1'b0; address_line = '0;
`ifdef TEST_PATTERN_EN
        test_mode = 1'b0;
`endif
        repeat (3) @(posedge system_clk);
        @(negedge system_clk);
        check("rst_data_ready", 32'(data_ready), 32'd0);
        check("rst_data_line",  32'(data_line),  32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_sram_rd_en", 32'(sram_rd_en), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_req(vecs[i].addr, en_m, dr_m, fd_m, dl, a1, a2);
            check($sformatf("v%0d_en_mask", i), 32'(en_m), 32'(vecs[i].en_m));
            check($sformatf("v%0d_dr_mask", i), 32'(dr_m), 32'(vecs[i].dr_m));
            check($sformatf("v%0d_fd_mask", i), 32'(fd_m), 32'(vecs[i].fd_m));
            check($sformatf("v%0d_data",    i), 32'(dl),   32'(vecs[i].pix));
            if (vecs[i].en_m != 8'h00) begin
                check($sformatf("v%0d_addr_lo", i), 32'(a1), 32'({vecs[i].addr, 1'b0}));
                check($sformatf("v%0d_addr_hi", i), 32'(a2), 32'({vecs[i].addr, 1'b1}));
            end
        end

        // Level request held for 20 cycles: one fetch, one burst.
        @(negedge system_clk);
        read_request = 1'b1; address_line = 20'd7;
        strobes = 0; bursts = 0; prev = 1'b0;
        repeat (20) begin
            @(negedge system_clk);
            address_line = address_line + 20'd3;
            if (sram_rd_en) strobes++;
            if (data_ready && !prev) bursts++;
            prev = data_ready;
        end
        read_request = 1'b0;
        repeat (3) @(negedge system_clk);
        check("hold_strobes", 32'(strobes), 32'd2);
        check("hold_bursts",  32'(bursts),  32'd1);
        run_req(20'd7, en_m, dr_m, fd_m, dl, a1, a2);
        check("refetch_dr_mask", 32'(dr_m), 32'h30);
        check("refetch_data",    32'(dl),   32'(pix(20'd7)));

        // Reset mid-fetch: in-flight SRAM data must be dropped.
        @(negedge system_clk);
        read_request = 1'b1; address_line = 20'd7;
        @(posedge system_clk);
        @(negedge system_clk);
        read_request = 1'b0;
        @(negedge system_clk);
        rst = 1'b1;
        repeat (2) @(posedge system_clk);
        @(negedge system_clk);
        check("mid_rst_data_ready", 32'(data_ready), 32'd0);
        check("mid_rst_data_line",  32'(data_line),  32'd0);
        check("mid_rst_frame_done", 32'(frame_done), 32'd0);
        check("mid_rst_sram_rd_en", 32'(sram_rd_en), 32'd0);
        rst = 1'b0;
        dr_m = '0; en_m = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge system_clk);
            dr_m[k] = data_ready;
            en_m[k] = sram_rd_en;
        end
        check("post_rst_no_dr", 32'(dr_m), 32'd0);
        check("post_rst_no_en", 32'(en_m), 32'd0);
        run_req(20'd1, en_m, dr_m, fd_m, dl, a1, a2);
        check("post_rst_dr_mask", 32'(dr_m), 32'h30);
        check("post_rst_data",    32'(dl),   32'(pix(20'd1)));

`ifdef TEST_PATTERN_EN
        test_mode = 1'b1;
        run_req(20'd650, en_m, dr_m, fd_m, dl, a1, a2);
        check("tp650_en",   32'(en_m), 32'h00);
        check("tp650_dr",   32'(dr_m), 32'h03);
        check("tp650_data", 32'(dl),   32'h000000);
        run_req(20'd250, en_m, dr_m, fd_m, dl, a1, a2);
        check("tp250_dr",   32'(dr_m), 32'h03);
        check("tp250_data", 32'(dl),   32'h00FFFF);
        run_req(20'd307199, en_m, dr_m, fd_m, dl, a1, a2);
        check("tp_last_fd",   32'(fd_m), 32'h01);
        check("tp_last_data", 32'(dl),   32'hFFFFFF);
        test_mode = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
